em_ro_window_detector: RTL and testbench

//  Upstream front-end of the EM-sensor APB peripheral. Counts synchronized ring-oscillator

---
 rtl/em_sensor_pkg.sv | 16 +
 rtl/em_window_counter.sv | 42 ++++
 rtl/em_ro_window_detector.sv | 160 ++++++++++++++++
 tb/tb_em_ro_window_detector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/em_sensor_pkg.sv
// Shared definitions for the EM-sensor front-end and its APB wrapper:
// detector state encoding and default datapath sizes.
package em_sensor_pkg;

  localparam int EM_STATE_W  = 2;
  localparam int EM_CNT_W    = 16;
  localparam int EM_WIN_LOG2 = 8;

  typedef enum logic [EM_STATE_W-1:0] {
    IDLE  = 2'd0,
    CAL   = 2'd1,
    MON   = 2'd2,
    ALARM = 2'd3
  } em_state_t;

endpackage

// File: rtl/em_window_counter.sv
// Fixed-length window timer with a saturating oscillator-edge counter.
// window_done marks the terminal cycle; count already includes that cycle's edge.
module em_window_counter
  import em_sensor_pkg::*;
#(
  parameter int CNT_W    = EM_CNT_W,
  parameter int WIN_LOG2 = EM_WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             osc_edge,
  output logic             window_done,
  output logic [CNT_W-1:0] count
);

  logic [WIN_LOG2-1:0] win_pos;
  logic [CNT_W-1:0]    edge_cnt;
  logic                terminal;

  assign terminal    = &win_pos;
  assign window_done = run & ~clear & terminal;

  // Running total for this window, pinned at all-ones rather than wrapping.
  assign count = (&edge_cnt) ? edge_cnt : edge_cnt + CNT_W'(osc_edge);

  // Window position and edge accumulation; idle or cleared keeps both at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_pos  <= '0;
      edge_cnt <= '0;
    end else if (clear || !run) begin
      win_pos  <= '0;
      edge_cnt <= '0;
    end else begin
      win_pos  <= win_pos + WIN_LOG2'(1);
      edge_cnt <= terminal ? '0 : count;
    end
  end

endmodule

// File: rtl/em_ro_window_detector.sv
// Ring-oscillator window detector: calibrates a baseline edge count after enable,
// then raises a sticky alarm after CONSEC consecutive windows deviate by more than THRESH.
module em_ro_window_detector
  import em_sensor_pkg::*;
#(
  parameter int CNT_W    = EM_CNT_W,
  parameter int WIN_LOG2 = EM_WIN_LOG2,
  parameter int CAL_LOG2 = 2,
  parameter int THRESH   = 8,
  parameter int CONSEC   = 2
) (
  input  logic             vclk,
  input  logic             vrst,
  input  logic             en,
  input  logic             osc_edge,
  input  logic             recal,
  input  logic             alarm_clr,
  output logic             alarm,
  output logic             alarm_pulse,
  output logic             cal_done,
  output logic [CNT_W-1:0] win_count,
  output logic [CNT_W-1:0] baseline
);

  localparam int SUM_W = CNT_W + CAL_LOG2;
  localparam int IDX_W = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
  localparam int CON_W = $clog2(CONSEC + 1);
  localparam logic [IDX_W-1:0] CAL_LAST = IDX_W'((1 << CAL_LOG2) - 1);
  localparam logic [CON_W-1:0] CON_MAX  = CON_W'(CONSEC);
  localparam logic [CON_W-1:0] CON_PRE  = CON_W'(CONSEC - 1);
  localparam logic [CNT_W:0]   THRESH_V = (CNT_W + 1)'(THRESH);

  em_state_t state, state_next;

  logic                    run, clear, window_done;
  logic [CNT_W-1:0]        count;
  logic [IDX_W-1:0]        cal_idx;
  logic [SUM_W-1:0]        cal_sum, cal_total;
  logic [CON_W-1:0]        consec;
  logic signed [CNT_W:0]   diff;
  logic [CNT_W:0]          dev;
  logic                    cal_win, cal_last, cmp_win, viol, reach;

  assign run   = (state != IDLE);
  assign clear = ~en | recal;

  em_window_counter #(
    .CNT_W    (CNT_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .clk         (vclk),
    .rst         (vrst),
    .run         (run),
    .clear       (clear),
    .osc_edge    (osc_edge),
    .window_done (window_done),
    .count       (count)
  );

  // One extra bit keeps the signed difference exact for any count/baseline pair.
  assign diff      = $signed({1'b0, count}) - $signed({1'b0, baseline});
  assign dev       = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign viol      = dev > THRESH_V;
  assign cal_win   = window_done & (state == CAL);
  assign cal_last  = cal_win & (cal_idx == CAL_LAST);
  assign cmp_win   = window_done & ((state == MON) | (state == ALARM));
  assign reach     = cmp_win & viol & (consec == CON_PRE);
  assign cal_total = cal_sum + SUM_W'(count);

  // State register.
  always_ff @(posedge vclk) begin
    if (vrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: disable and recalibration override the normal progression.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else if (recal) begin
      state_next = CAL;
    end else begin
      case (state)
        IDLE:    state_next = cal_done ? MON : CAL;
        CAL:     state_next = cal_last ? MON : CAL;
        MON:     state_next = reach ? ALARM : MON;
        ALARM:   state_next = (alarm_clr && !reach) ? MON : ALARM;
        default: state_next = IDLE;
      endcase
    end
  end

  // Window result, calibration accumulator and consecutive-violation counter.
  always_ff @(posedge vclk) begin
    if (vrst) begin
      win_count <= '0;
      baseline  <= '0;
      cal_done  <= 1'b0;
      cal_sum   <= '0;
      cal_idx   <= '0;
      consec    <= '0;
    end else if (clear) begin
      cal_sum <= '0;
      cal_idx <= '0;
      consec  <= '0;
      if (recal) begin
        cal_done  <= 1'b0;
        baseline  <= '0;
        win_count <= '0;
      end
    end else begin
      if (window_done) begin
        win_count <= count;
      end
      if (cal_last) begin
        baseline <= cal_total[SUM_W-1:CAL_LOG2];
        cal_done <= 1'b1;
        cal_sum  <= '0;
        cal_idx  <= '0;
      end else if (cal_win) begin
        cal_sum <= cal_total;
        cal_idx <= cal_idx + IDX_W'(1);
      end
      // A reaching violation outranks a same-cycle clear.
      if (reach) begin
        consec <= CON_MAX;
      end else if (alarm_clr) begin
        consec <= '0;
      end else if (cmp_win) begin
        if (!viol) begin
          consec <= '0;
        end else if (consec == CON_MAX) begin
          consec <= CON_MAX;
        end else begin
          consec <= consec + CON_W'(1);
        end
      end
    end
  end

  // Sticky alarm; set wins over clear and the strobe fires only on a 0->1 change.
  always_ff @(posedge vclk) begin
    if (vrst) begin
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      alarm_pulse <= reach & ~alarm;
      if (reach) begin
        alarm <= 1'b1;
      end else if (alarm_clr) begin
        alarm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_em_ro_window_detector.sv
// Randomized self-checking bench: window-level reference model of calibration,
// deviation and sticky-alarm rules, plus a CNT_W=8 instance for saturation.
module tb_em_ro_window_detector;

  localparam int WIN = 256;
  localparam int THR = 8;
  localparam int NCONS = 2;

  logic vclk = 1'b0;
  logic vrst, en, osc_edge, recal, alarm_clr;
  logic alarm, alarm_pulse, cal_done;
  logic [15:0] win_count, baseline;

  logic en2, osc2, zero2;
  logic alarm2, pulse2, cal_done2;
  logic [7:0] win_count2, baseline2;

  em_ro_window_detector #(.CNT_W(16), .WIN_LOG2(8), .CAL_LOG2(2), .THRESH(THR), .CONSEC(NCONS)) dut (
    .vclk(vclk), .vrst(vrst), .en(en), .osc_edge(osc_edge), .recal(recal), .alarm_clr(alarm_clr),
    .alarm(alarm), .alarm_pulse(alarm_pulse), .cal_done(cal_done),
    .win_count(win_count), .baseline(baseline)
  );

  em_ro_window_detector #(.CNT_W(8), .WIN_LOG2(8), .CAL_LOG2(2), .THRESH(THR), .CONSEC(NCONS)) dut_sat (
    .vclk(vclk), .vrst(vrst), .en(en2), .osc_edge(osc2), .recal(zero2), .alarm_clr(zero2),
    .alarm(alarm2), .alarm_pulse(pulse2), .cal_done(cal_done2),
    .win_count(win_count2), .baseline(baseline2)
  );

  always #5 vclk = ~vclk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model state, updated once per completed window or control event.
  bit m_cal_done, m_alarm, m_pulse;
  int m_baseline, m_win, m_run;
  int m_cal[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge vclk);
    #1;
  endtask

  task automatic check_outputs;
    check_value("win_count", win_count, m_win);
    check_value("baseline", baseline, m_baseline);
    check_value("cal_done", cal_done, m_cal_done);
    check_value("alarm", alarm, m_alarm);
    check_value("alarm_pulse", alarm_pulse, m_pulse);
  endtask

  task automatic model_reset;
    m_cal_done = 0; m_alarm = 0; m_pulse = 0;
    m_baseline = 0; m_win = 0; m_run = 0;
    m_cal.delete();
  endtask

  // Evenly spread k edges over the window, rotated by a random phase.
  function automatic bit edge_at(int i, int k, int ph);
    int j;
    j = (i + ph) % WIN;
    return (((j + 1) * k) / WIN - (j * k) / WIN) != 0;
  endfunction

  function automatic void model_window(int k, bit clr_last);
    int sum, dev;
    bit set;
    m_pulse = 0;
    m_win = k;
    if (!m_cal_done) begin
      m_cal.push_back(k);
      if (m_cal.size() == 4) begin
        sum = 0;
        foreach (m_cal[q]) sum += m_cal[q];
        m_baseline = sum / 4;
        m_cal_done = 1;
        m_cal.delete();
      end
      if (clr_last) m_alarm = 0;
    end else begin
      dev = (k > m_baseline) ? k - m_baseline : m_baseline - k;
      set = 0;
      if (dev > THR) begin
        m_run++;
        set = (m_run == NCONS);
      end else begin
        m_run = 0;
      end
      if (set) begin
        m_pulse = !m_alarm;
        m_alarm = 1;
      end else if (clr_last) begin
        m_alarm = 0;
        m_run = 0;
      end
    end
  endfunction

  // One full window with k edges; optional alarm_clr pulse at cycle clr_pos.
  task automatic run_window(input int k, input int clr_pos);
    int ph;
    ph = $urandom_range(0, WIN - 1);
    for (int i = 0; i < WIN; i++) begin
      osc_edge = edge_at(i, k, ph);
      alarm_clr = (i == clr_pos);
      tick;
      if (i == 0) check_value("pulse_one_cycle", alarm_pulse, 1'b0);
      if (i == clr_pos && i < WIN - 1) begin
        m_alarm = 0;
        m_run = 0;
      end
    end
    osc_edge = 1'b0;
    alarm_clr = 1'b0;
    model_window(k, clr_pos == WIN - 1);
    check_outputs();
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      osc_edge = 1'($urandom_range(0, 1));
      tick;
    end
    osc_edge = 1'b0;
  endtask

  task automatic start;
    en = 1'b1;
    osc_edge = 1'b0;
    tick;
  endtask

  task automatic do_recal(input int n);
    partial(n);
    recal = 1'b1;
    tick;
    recal = 1'b0;
    m_cal_done = 0; m_baseline = 0; m_win = 0; m_run = 0; m_pulse = 0;
    m_cal.delete();
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    partial(n);
    vrst = 1'b1;
    tick;
    model_reset();
    check_outputs();
    vrst = 1'b0;
    start();
  endtask

  task automatic en_toggle(input int n);
    partial(n);
    en = 1'b0;
    tick;
    if (!m_cal_done) m_cal.delete();
    m_run = 0;
    m_pulse = 0;
    check_outputs();
    start();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, off, cp;
    vrst = 1'b1; en = 1'b0; osc_edge = 1'b0; recal = 1'b0; alarm_clr = 1'b0;
    en2 = 1'b0; osc2 = 1'b0; zero2 = 1'b0;
    model_reset();
    tick;
    tick;
    check_outputs();
    vrst = 1'b0;
    tick;
    check_outputs();

    // Saturation: edge every cycle on the 8-bit instance.
    en2 = 1'b1;
    tick;
    for (int w = 0; w < 2; w++) begin
      osc2 = 1'b1;
      for (int i = 0; i < WIN; i++) tick;
      check_value("sat_win_count", win_count2, 8'd255);
    end
    check_value("sat_cal_done", cal_done2, 1'b0);
    check_value("sat_alarm", alarm2, 1'b0);
    check_value("sat_pulse", pulse2, 1'b0);
    check_value("sat_baseline", baseline2, 8'd0);
    en2 = 1'b0;
    osc2 = 1'b0;

    // Calibration at 128 edges per window, then attack at 64.
    start();
    for (int w = 0; w < 4; w++) run_window(128, -1);
    run_window(64, -1);
    run_window(64, -1);
    run_window(128, 100);
    run_window(64, -1);
    run_window(128, -1);

    // Threshold boundary on both sides of the baseline.
    for (int w = 0; w < 3; w++) run_window(136, -1);
    run_window(137, -1);
    run_window(137, -1);
    run_window(137, 100);
    run_window(137, -1);
    run_window(128, 100);
    run_window(137, -1);
    run_window(137, WIN - 1);
    run_window(120, 50);
    run_window(120, -1);
    run_window(119, -1);
    run_window(119, -1);

    // Recalibration mid-monitor keeps the alarm; reset mid-calibration clears all.
    do_recal(100);
    for (int w = 0; w < 4; w++) run_window($urandom_range(100, 200), -1);
    run_window(m_baseline + 20, -1);
    do_recal(37);
    run_window($urandom_range(100, 200), -1);
    run_window($urandom_range(100, 200), -1);
    do_reset(77);
    for (int w = 0; w < 4; w++) run_window($urandom_range(100, 200), -1);

    // Randomized monitoring around the baseline, with clears and enable drops.
    for (int w = 0; w < 24; w++) begin
      off = $urandom_range(0, 28);
      k = m_baseline + off - 14;
      cp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WIN - 2) : -1;
      if ($urandom_range(0, 7) == 0) en_toggle($urandom_range(1, WIN - 1));
      run_window(k, cp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
